tone_freq_detector: RTL and testbench

Measures the pitch of a 16-bit offset-binary audio sample stream and reports it as a 16-bit `tone_freq` phase increment in the same units the tone generator consumes.
- Definition: `tone_freq = 2^24 / period_in_clk_cycles`.
- Method: rising-edge zero-crossing detection with hysteresis, a cycle counter averaged over PERIODS periods, and a sequential restoring divider.
- Use: guitar-pitch tracking, and closed-loop self-test of the synthesis path.

---
 rtl/tone_freq_detector_pkg.sv | 16 +
 rtl/tone_freq_detector_if.sv | 19 +
 rtl/tone_freq_detector_divider.sv | 67 ++++++
 rtl/tone_freq_detector.sv | 135 +++++++++++++
 tb/tb_tone_freq_detector.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tone_freq_detector_pkg.sv
// Shared constants and helpers for the tone frequency detector.
//   MIDPOINT   : offset-binary zero level of the audio samples
//   PHASE_BITS : phase accumulator width of the tone generator (2^24 = one cycle)
//   QUOT_W     : divider quotient width
//   sat16()    : clamp a quotient to the 16-bit phase-increment range
package tone_freq_detector_pkg;

    localparam logic [15:0] MIDPOINT   = 16'h8000;
    localparam int          PHASE_BITS = 24;
    localparam int          QUOT_W     = 32;

    function automatic logic [15:0] sat16(input logic [QUOT_W-1:0] q);
        return (|q[QUOT_W-1:16]) ? 16'hFFFF : q[15:0];
    endfunction

endpackage

// File: rtl/tone_freq_detector_if.sv
// Sample-in / measurement-out bundle of the tone frequency detector.
//   din_valid, din : qualified offset-binary sample stream (master -> slave)
//   tone_freq      : last measured phase increment        (slave -> master)
//   freq_valid     : one-cycle strobe on tone_freq update
//   locked         : nonzero measurements are being produced
//   busy           : divider running
interface tone_freq_detector_if;
    logic        din_valid;
    logic [15:0] din;
    logic [15:0] tone_freq;
    logic        freq_valid;
    logic        locked;
    logic        busy;

    modport master (output din_valid, din,
                    input  tone_freq, freq_valid, locked, busy);
    modport slave  (input  din_valid, din,
                    output tone_freq, freq_valid, locked, busy);
endinterface

// File: rtl/tone_freq_detector_divider.sv
// seq_divider_restoring: unsigned restoring divider, one quotient bit per cycle.
//   clk, rst_n : clock, async active-low reset
//   start      : load operands (ignored while busy)
//   abort      : drop the divide in progress, no done pulse
//   dividend   : N_W-bit numerator,  divisor : D_W-bit denominator (nonzero)
//   busy       : high for N_W cycles starting the cycle after start
//   done       : one-cycle pulse after the last iteration, quotient valid then
module seq_divider_restoring #(
    parameter int N_W = 32,
    parameter int D_W = 28
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] quotient
);
    localparam int CB = $clog2(N_W);

    logic [CB-1:0]  cnt;
    logic [D_W-1:0] den;
    logic [D_W-1:0] rem;
    // quo starts as the dividend; each iteration shifts one dividend bit out
    // of the top into the partial remainder and one quotient bit in at the bottom.
    logic [N_W-1:0] quo;
    logic [D_W:0]   rem_sh;
    logic           ge;

    assign rem_sh   = {rem, quo[N_W-1]};
    assign ge       = rem_sh >= {1'b0, den};
    assign quotient = quo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
            den  <= '0;
            rem  <= '0;
            quo  <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
            end else if (start && !busy) begin
                busy <= 1'b1;
                cnt  <= '0;
                den  <= divisor;
                rem  <= '0;
                quo  <= dividend;
            end else if (busy) begin
                // remainder stays below den, so it always fits back in D_W bits
                rem <= ge ? D_W'(rem_sh - {1'b0, den}) : D_W'(rem_sh);
                quo <= {quo[N_W-2:0], ge};
                cnt <= cnt + CB'(1);
                if (cnt == CB'(N_W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/tone_freq_detector.sv
// Pitch meter: reports tone_freq = PERIODS * 2^24 / (cycles spanned by PERIODS
// signal periods), the phase increment the tone generator would need.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of tone_freq_detector_if (samples in, result out)
// Rising zero crossings with hysteresis delimit the periods; a window of
// PERIODS crossings is timed in clk cycles and handed to a sequential divider.
module tone_freq_detector
    import tone_freq_detector_pkg::*;
#(
    parameter int unsigned PERIODS = 4,
    parameter logic [15:0] HYST    = 16'd1024,
    parameter int unsigned CNT_W   = 28
) (
    input  logic clk,
    input  logic rst_n,
    tone_freq_detector_if.slave bus
);
    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_MEASURE = 1'b1;

    localparam logic [15:0]       ARM_TH    = MIDPOINT - HYST;
    localparam logic [15:0]       FIRE_TH   = MIDPOINT + HYST;
    localparam logic [CNT_W-1:0]  CYC_MAX   = '1;
    localparam logic [7:0]        PCNT_LAST = 8'(PERIODS - 1);
    localparam logic [QUOT_W-1:0] DIVIDEND  = QUOT_W'(PERIODS) << PHASE_BITS;

    logic [0:0]        state;
    logic              armed;
    logic [CNT_W-1:0]  cyc;
    logic [7:0]        pcnt;
    logic              xing;
    logic              timeout;
    logic              win_end;
    logic              div_busy;
    logic              div_done;
    logic [QUOT_W-1:0] div_quot;
    logic [15:0]       tone_freq_r;
    logic              freq_valid_r;
    logic              locked_r;

    // ---- crossing detector ----
    assign xing = bus.din_valid && armed && (bus.din >= FIRE_TH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            armed <= 1'b0;
        else if (bus.din_valid) begin
            if (bus.din <= ARM_TH)
                armed <= 1'b1;
            else if (xing)
                armed <= 1'b0;
        end
    end

    // ---- window FSM ----
    // Timeout outranks any crossing in the same cycle, so it also masks win_end.
    assign timeout = (state == S_MEASURE) && (cyc == CYC_MAX);
    assign win_end = (state == S_MEASURE) && xing && (pcnt == PCNT_LAST) && !timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cyc   <= '0;
            pcnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (xing) begin
                        state <= S_MEASURE;
                        cyc   <= '0;
                        pcnt  <= '0;
                    end
                end
                default: begin
                    if (timeout) begin
                        state <= S_IDLE;
                    end else if (win_end) begin
                        // the closing crossing also opens the next window
                        cyc  <= '0;
                        pcnt <= '0;
                    end else begin
                        cyc <= cyc + CNT_W'(1);
                        if (xing)
                            pcnt <= pcnt + 8'd1;
                    end
                end
            endcase
        end
    end

    // ---- divider ----
    // A window ending while the divider is busy is simply not launched.
    // done arrives a cycle after busy drops, so a window ending on the
    // finishing cycle sees busy low and is accepted.
    seq_divider_restoring #(
        .N_W (QUOT_W),
        .D_W (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (win_end),
        .abort    (timeout),
        .dividend (DIVIDEND),
        .divisor  (cyc + CNT_W'(1)),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    // ---- result ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_freq_r  <= '0;
            freq_valid_r <= 1'b0;
            locked_r     <= 1'b0;
        end else begin
            freq_valid_r <= 1'b0;
            if (timeout) begin
                tone_freq_r  <= '0;
                freq_valid_r <= 1'b1;
                locked_r     <= 1'b0;
            end else if (div_done) begin
                tone_freq_r  <= sat16(div_quot);
                freq_valid_r <= 1'b1;
                if (div_quot != '0)
                    locked_r <= 1'b1;
            end
        end
    end

    assign bus.tone_freq  = tone_freq_r;
    assign bus.freq_valid = freq_valid_r;
    assign bus.locked     = locked_r;
    assign bus.busy       = div_busy;
endmodule

// File: tb/tb_tone_freq_detector.sv
// Scoreboard bench for tone_freq_detector. The driver watches its own stimulus
// for rising crossings (arm <= 0x7C00, fire >= 0x8400) and, at each window end
// the divider would accept, queues the hand-computed result due 34 cycles later.
// Monitors pop and compare on every freq_valid and check busy pulse lengths.
module tb_tone_freq_detector;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    tone_freq_detector_if bus_m ();
    tone_freq_detector_if bus_t ();

    tone_freq_detector u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_m)
    );

    // short counter so the timeout is reachable in simulation
    tone_freq_detector #(.CNT_W(12)) u_to (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_t)
    );

    typedef struct {
        logic [15:0] freq;
        logic        locked;
        int          cyc;
    } exp_t;

    exp_t q_m[$];
    exp_t q_t[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    // ---- monitors ----
    int run_m = 0;
    int run_t = 0;

    task automatic mon_one(input int which, input logic fv, input logic [15:0] f,
                           input logic lk, input logic bz, inout int run);
        string nm;
        exp_t  e;
        nm = (which != 0) ? "to" : "main";
        if (!rst_n) begin
            run = 0;
        end else begin
            if (bz) run++;
            else if (run != 0) begin
                chk({nm, " busy_len"}, 64'(run), 64'd32);
                run = 0;
            end
            if (fv) begin
                if ((which != 0 && q_t.size() == 0) || (which == 0 && q_m.size() == 0)) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL %s unexpected_strobe: actual tone_freq %0h at cycle %0d, required none",
                             nm, f, cycle);
                end else begin
                    if (which != 0) e = q_t.pop_front();
                    else            e = q_m.pop_front();
                    chk({nm, " tone_freq"}, 64'(f), 64'(e.freq));
                    chk({nm, " locked"}, 64'(lk), 64'(e.locked));
                    chk({nm, " strobe_cycle"}, 64'(cycle), 64'(e.cyc));
                end
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        mon_one(0, bus_m.freq_valid, bus_m.tone_freq, bus_m.locked, bus_m.busy, run_m);
        mon_one(1, bus_t.freq_valid, bus_t.tone_freq, bus_t.locked, bus_t.busy, run_t);
    end

    // ---- driver with crossing tracker ----
    int          tgt = 0;
    bit          tr_armed = 1'b0;
    int          xcount = 0;
    int          last_launch = -1000;
    int          last_xing = 0;
    logic [15:0] exp_val = 16'h0;
    logic [23:0] acc = 24'h0;

    task automatic push_exp(input logic [15:0] f, input logic lk, input int c);
        exp_t e;
        e.freq = f;
        e.locked = lk;
        e.cyc = c;
        if (tgt != 0) q_t.push_back(e);
        else          q_m.push_back(e);
    endtask

    task automatic on_xing();
        last_xing = cycle;
        // divider busy cycles are launch+1 .. launch+32
        if (xcount > 0 && (xcount % 4) == 0 && cycle >= last_launch + 33) begin
            push_exp(exp_val, 1'b1, cycle + 34);
            last_launch = cycle;
        end
        xcount++;
    endtask

    task automatic step(input logic v, input logic [15:0] d);
        @(posedge clk);
        #1;
        if (tgt == 0) begin
            bus_m.din_valid = v;    bus_m.din = d;
            bus_t.din_valid = 1'b0; bus_t.din = 16'h8000;
        end else begin
            bus_t.din_valid = v;    bus_t.din = d;
            bus_m.din_valid = 1'b0; bus_m.din = 16'h8000;
        end
        if (v) begin
            if (d <= 16'h7C00) tr_armed = 1'b1;
            else if (tr_armed && d >= 16'h8400) begin
                tr_armed = 1'b0;
                on_xing();
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h8000);
    endtask

    task automatic sq(input int lo_len, input int hi_len, input int nper,
                      input logic [15:0] lo, input logic [15:0] hi);
        for (int p = 0; p < nper; p++) begin
            for (int j = 0; j < lo_len; j++) step(1'b1, lo);
            for (int j = 0; j < hi_len; j++) step(1'b1, hi);
        end
    endtask

    task automatic do_reset(input bit flush);
        if (!flush) begin
            chk("queue_drained_main", 64'(q_m.size()), 64'd0);
            chk("queue_drained_to", 64'(q_t.size()), 64'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst tone_freq_main", 64'(bus_m.tone_freq), 64'd0);
        chk("rst freq_valid_main", 64'(bus_m.freq_valid), 64'd0);
        chk("rst locked_main", 64'(bus_m.locked), 64'd0);
        chk("rst busy_main", 64'(bus_m.busy), 64'd0);
        chk("rst tone_freq_to", 64'(bus_t.tone_freq), 64'd0);
        chk("rst freq_valid_to", 64'(bus_t.freq_valid), 64'd0);
        chk("rst locked_to", 64'(bus_t.locked), 64'd0);
        chk("rst busy_to", 64'(bus_t.busy), 64'd0);
        q_m.delete();
        q_t.delete();
        tr_armed = 1'b0;
        xcount = 0;
        last_launch = -1000;
        acc = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] tri_v;
        bus_m.din_valid = 1'b0; bus_m.din = 16'h8000;
        bus_t.din_valid = 1'b0; bus_t.din = 16'h8000;

        // saw, tone 0x4000: period 1024, window 4096 -> 0x4000
        tgt = 0;
        do_reset(0);
        exp_val = 16'h4000;
        for (int i = 0; i < 9 * 1024; i++) begin
            step(1'b1, acc[23:8]);
            acc = acc + 24'h004000;
        end
        idle(40);

        // triangle, tone 0x2000: period 2048, window 8192 -> 0x2000
        do_reset(0);
        exp_val = 16'h2000;
        for (int i = 0; i < 9 * 2048; i++) begin
            tri_v = acc[23] ? ~acc[22:7] : acc[22:7];
            step(1'b1, tri_v);
            acc = acc + 24'h002000;
        end
        idle(40);

        // 300/700 square with unqualified opposite-level samples and in-band
        // noise mixed in: window 4000 -> floor(2^26/4000) = 16777 = 0x4189
        do_reset(0);
        exp_val = 16'h4189;
        for (int p = 0; p < 9; p++) begin
            for (int j = 0; j < 300; j++) begin
                case (j % 3)
                    0:       step(1'b1, 16'h0000);
                    1:       step(1'b0, 16'hFFFF);
                    default: step(1'b1, 16'h83E8);
                endcase
            end
            for (int j = 0; j < 700; j++) begin
                if ((j % 7) == 6)      step(1'b0, 16'h0000);
                else if ((j % 5) == 4) step(1'b1, 16'h7C18);
                else                   step(1'b1, 16'hFFFF);
            end
        end
        idle(40);

        // thresholds: just inside the band never arms; exactly on them does.
        // window 12000 -> floor(2^26/12000) = 5592 = 0x15D8
        do_reset(0);
        exp_val = 16'h15D8;
        for (int i = 0; i < 200; i++) step(1'b1, (i % 2) ? 16'h83FF : 16'h7C01);
        sq(1500, 1500, 5, 16'h7C00, 16'h8400);
        idle(40);

        // saturation edge: window 1028 -> 0xFF00, window 1024 -> 0x10000 -> 0xFFFF
        do_reset(0);
        exp_val = 16'hFF00;
        sq(128, 129, 5, 16'h0000, 16'hFFFF);
        idle(40);
        do_reset(0);
        exp_val = 16'hFFFF;
        sq(128, 128, 5, 16'h0000, 16'hFFFF);
        idle(40);

        // period 128: quotient 131072 -> 0xFFFF, two windows
        do_reset(0);
        exp_val = 16'hFFFF;
        sq(64, 64, 9, 16'h0000, 16'hFFFF);
        idle(40);

        // period 8: window 32 < divide latency, every other window dropped
        do_reset(0);
        exp_val = 16'hFFFF;
        sq(4, 4, 25, 16'h0000, 16'hFFFF);
        idle(40);

        // reset mid-divide: the pending result must never appear
        do_reset(0);
        exp_val = 16'hFFFF;
        sq(64, 64, 4, 16'h0000, 16'hFFFF);
        sq(64, 10, 1, 16'h0000, 16'hFFFF);
        chk("busy_before_midreset", 64'(bus_m.busy), 64'd1);
        do_reset(1);
        sq(64, 64, 5, 16'h0000, 16'hFFFF);
        idle(40);

        // timeout (CNT_W=12): one window locks, then in-band noise only
        tgt = 1;
        do_reset(0);
        exp_val = 16'hFFFF;
        sq(50, 50, 5, 16'h0000, 16'hFFFF);
        push_exp(16'h0000, 1'b0, last_xing + 4097);
        for (int i = 0; i < 6200; i++)
            step(1'b1, 16'($urandom_range(32'h8000 - 1000, 32'h8000 + 1000)));
        idle(50);

        chk("final_queue_main", 64'(q_m.size()), 64'd0);
        chk("final_queue_to", 64'(q_t.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
